// File: rtl/vga_pkg.sv
// Raster constant sets and total-length helpers shared by the VGA timing generator.
package vga_pkg;

   localparam logic SYNC_ACTIVE_LOW  = 1'b0;
   localparam logic SYNC_ACTIVE_HIGH = 1'b1;

   // 640x480@60, 25.175 MHz pixel clock
   localparam int   VGA640_H_ACTIVE = 640;
   localparam int   VGA640_H_FP     = 16;
   localparam int   VGA640_H_SYNC   = 96;
   localparam int   VGA640_H_BP     = 48;
   localparam int   VGA640_V_ACTIVE = 480;
   localparam int   VGA640_V_FP     = 10;
   localparam int   VGA640_V_SYNC   = 2;
   localparam int   VGA640_V_BP     = 33;
   localparam logic VGA640_HS_POL   = SYNC_ACTIVE_LOW;
   localparam logic VGA640_VS_POL   = SYNC_ACTIVE_LOW;

   // 800x600@60, 40 MHz pixel clock
   localparam int   SVGA800_H_ACTIVE = 800;
   localparam int   SVGA800_H_FP     = 40;
   localparam int   SVGA800_H_SYNC   = 128;
   localparam int   SVGA800_H_BP     = 88;
   localparam int   SVGA800_V_ACTIVE = 600;
   localparam int   SVGA800_V_FP     = 1;
   localparam int   SVGA800_V_SYNC   = 4;
   localparam int   SVGA800_V_BP     = 23;
   localparam logic SVGA800_HS_POL   = SYNC_ACTIVE_HIGH;
   localparam logic SVGA800_VS_POL   = SYNC_ACTIVE_HIGH;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return axis_total(active, fp, sync, bp);
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return axis_total(active, fp, sync, bp);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-area and raw sync decode.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter int CW     = 12
) (
   input  logic          mclk,
   input  logic          rst_n,
   input  logic          adv,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          active,
   output logic          sync_raw
);

   localparam int            TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
   localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (adv)
         count <= wrap ? '0 : count + CW'(1);
   end

   assign wrap     = (count == LAST);
   assign active   = (count < ACT_END);
   assign sync_raw = (count >= SYNC_BEG) && (count < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, coordinate
// request stage and a registered sync/colour stage aligned at the connector.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   CLK_DIV  = 2,
   parameter int   H_ACTIVE = VGA640_H_ACTIVE,
   parameter int   H_FP     = VGA640_H_FP,
   parameter int   H_SYNC   = VGA640_H_SYNC,
   parameter int   H_BP     = VGA640_H_BP,
   parameter int   V_ACTIVE = VGA640_V_ACTIVE,
   parameter int   V_FP     = VGA640_V_FP,
   parameter int   V_SYNC   = VGA640_V_SYNC,
   parameter int   V_BP     = VGA640_V_BP,
   parameter logic HS_POL   = VGA640_HS_POL,
   parameter logic VS_POL   = VGA640_VS_POL,
   parameter int   CW       = 12,
   parameter int   R_W      = 3,
   parameter int   G_W      = 3,
   parameter int   B_W      = 2
) (
   input  logic           mclk,
   input  logic           rst_n,
   input  logic           en,
   output logic [CW-1:0]  pix_x,
   output logic [CW-1:0]  pix_y,
   output logic           pix_de,
   input  logic [R_W-1:0] rgb_r_in,
   input  logic [G_W-1:0] rgb_g_in,
   input  logic [B_W-1:0] rgb_b_in,
   output logic           Hsync,
   output logic           Vsync,
   output logic [R_W-1:0] OutRed,
   output logic [G_W-1:0] OutGreen,
   output logic [B_W-1:0] OutBlue,
   output logic           de_out,
   output logic           frame_start,
   output logic           line_start
);

   localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0]  div_cnt;
   logic           pix_en;
   logic           run_q;
   logic [CW-1:0]  h_cnt, v_cnt;
   logic           h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
   logic           line_home, frame_home;
   logic           de1, hs1, vs1, de2, hs2, vs2;
   logic [R_W-1:0] red2;
   logic [G_W-1:0] green2;
   logic [B_W-1:0] blue2;

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n)
         div_cnt <= '0;
      else if (en)
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
   end

   assign pix_en = en && (div_cnt == DIV_LAST);

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
   ) u_h_axis (
      .mclk(mclk), .rst_n(rst_n), .adv(pix_en),
      .count(h_cnt), .wrap(h_wrap), .active(h_act), .sync_raw(h_sync)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
   ) u_v_axis (
      .mclk(mclk), .rst_n(rst_n), .adv(pix_en && h_wrap),
      .count(v_cnt), .wrap(v_wrap), .active(v_act), .sync_raw(v_sync)
   );

   // line_home/frame_home remember that the last advance wrapped, i.e. the
   // counters now sit at h=0 / (0,0); both hold after reset.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         run_q       <= 1'b0;
         line_home   <= 1'b1;
         frame_home  <= 1'b1;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         de1         <= 1'b0;
         hs1         <= 1'b0;
         vs1         <= 1'b0;
         de2         <= 1'b0;
         hs2         <= 1'b0;
         vs2         <= 1'b0;
         red2        <= '0;
         green2      <= '0;
         blue2       <= '0;
      end else begin
         run_q       <= en;
         frame_start <= pix_en && line_home && frame_home;
         line_start  <= pix_en && line_home;
         if (pix_en) begin
            line_home  <= h_wrap;
            frame_home <= h_wrap && v_wrap;
            pix_x      <= h_cnt;
            pix_y      <= v_cnt;
            de1        <= h_act && v_act;
            hs1        <= h_sync;
            vs1        <= v_sync;
            de2        <= de1;
            hs2        <= hs1;
            vs2        <= vs1;
            red2       <= de1 ? rgb_r_in : '0;
            green2     <= de1 ? rgb_g_in : '0;
            blue2      <= de1 ? rgb_b_in : '0;
         end
      end
   end

   // Pipeline contents survive en=0 so the raster resumes seamlessly; only the
   // visible outputs are forced idle while stopped.
   assign pix_de   = de1 && run_q;
   assign de_out   = de2 && run_q;
   assign Hsync    = (hs2 && run_q) ? HS_POL : ~HS_POL;
   assign Vsync    = (vs2 && run_q) ? VS_POL : ~VS_POL;
   assign OutRed   = run_q ? red2   : '0;
   assign OutGreen = run_q ? green2 : '0;
   assign OutBlue  = run_q ? blue2  : '0;

endmodule
